sprite_fetch: RTL and testbench

// - Read-side engine for the single-port sprite ROMs. Per VGA pixel it tests whether (DrawX,DrawY) falls inside a

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_anim_ctr.sv | 60 ++++++
 rtl/sprite_fetch.sv | 119 +++++++++++
 tb/tb_sprite_fetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pkg
//  Purpose  : Shared widths, colour type and helpers for the sprite fetch
//             engine and its animation counter.
//  Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    localparam int ADDR_W = 19;
    localparam int RGB_W  = 24;

    typedef logic [23:0] rgb_t;

    // Magenta is the colour key the art pipeline uses for see-through texels
    localparam rgb_t SPR_KEY_DEFAULT = 24'hFF00FF;

    // Width of a counter/selector holding 0..n-1; never collapses to zero bits
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_anim_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_anim_ctr
//  Purpose  : Divides the per-frame tick by ANIM_DIV and steps the animation
//             frame index, wrapping NUM_FRAMES-1 back to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_anim_ctr
    import sprite_pkg::*;
#(
    parameter int  NUM_FRAMES = 3,
    parameter int  ANIM_DIV   = 6,
    localparam int FSEL_W     = sel_width(NUM_FRAMES),
    localparam int DIV_W      = sel_width(ANIM_DIV)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_frame_tick,
    input  logic              i_anim_en,
    output logic [FSEL_W-1:0] o_frame_sel
);

    localparam logic [DIV_W-1:0]  c_div_last   = DIV_W'(ANIM_DIV - 1);
    localparam logic [FSEL_W-1:0] c_frame_last = FSEL_W'(NUM_FRAMES - 1);

    logic [DIV_W-1:0]  div_d,   div_q;
    logic [FSEL_W-1:0] frame_d, frame_q;

    // Next-state: disabled animation parks on frame 0, otherwise count ticks
    always_comb begin
        div_d   = div_q;
        frame_d = frame_q;
        if (!i_anim_en) begin
            div_d   = '0;
            frame_d = '0;
        end else if (i_frame_tick) begin
            if (div_q == c_div_last) begin
                div_d   = '0;
                frame_d = (frame_q == c_frame_last) ? '0 : frame_q + FSEL_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Divider and frame index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            frame_q <= '0;
        end else begin
            div_q   <= div_d;
            frame_q <= frame_d;
        end
    end

    assign o_frame_sel = frame_q;

endmodule
`default_nettype wire

// File: rtl/sprite_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_fetch
//  Purpose  : Per-pixel sprite box test, ROM address generation (with
//             horizontal mirroring), colour-key filtering of the ROM word and
//             animation frame sequencing. Fixed 3-clock pixel latency.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_fetch
    import sprite_pkg::*;
#(
    parameter int   SPR_W       = 32,
    parameter int   SPR_H       = 32,
    parameter int   NUM_FRAMES  = 3,
    parameter int   ANIM_DIV    = 6,
    parameter rgb_t TRANSPARENT = SPR_KEY_DEFAULT,
    localparam int  FSEL_W      = sel_width(NUM_FRAMES)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              frame_tick,
    input  logic [9:0]        SpriteX,
    input  logic [9:0]        SpriteY,
    input  logic              flip,
    input  logic              anim_en,
    output logic [ADDR_W-1:0] read_address,
    input  rgb_t              rom_data,
    output logic [FSEL_W-1:0] frame_sel,
    output logic [RGB_W-1:0]  pixel_rgb,
    output logic              pixel_valid
);

    // Shadow copies of the sprite placement, only refreshed in vertical blank
    logic [9:0]        sx_d, sx_q;
    logic [9:0]        sy_d, sy_q;
    logic              flip_d, flip_q;

    // Pipeline state
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              hit1_d, hit1_q;
    logic              hit2_d, hit2_q;
    logic              valid_d, valid_q;
    rgb_t              rgb_d, rgb_q;

    // Stage-0 helpers; bit 10 of rel_* is the two's-complement sign
    logic [10:0]       rel_x;
    logic [10:0]       rel_y;
    logic              hit0;
    logic [ADDR_W-1:0] col;

    // Shadow load, box test, address generation and colour-key filtering
    always_comb begin
        sx_d   = sx_q;
        sy_d   = sy_q;
        flip_d = flip_q;
        if (frame_tick) begin
            sx_d   = SpriteX;
            sy_d   = SpriteY;
            flip_d = flip;
        end

        // A pixel left of / above the sprite gives a negative offset: a miss
        rel_x = {1'b0, DrawX} - {1'b0, sx_q};
        rel_y = {1'b0, DrawY} - {1'b0, sy_q};
        hit0  = !rel_x[10] && (rel_x < 11'(SPR_W)) &&
                !rel_y[10] && (rel_y < 11'(SPR_H));

        col    = flip_q ? (ADDR_W'(SPR_W - 1) - ADDR_W'(rel_x)) : ADDR_W'(rel_x);
        addr_d = hit0 ? (ADDR_W'(rel_y) * ADDR_W'(SPR_W) + col) : '0;
        hit1_d = hit0;

        // The ROM registers its word during the hit1 -> hit2 step
        hit2_d  = hit1_q;
        valid_d = hit2_q && (rom_data != TRANSPARENT);
        rgb_d   = valid_d ? rom_data : '0;
    end

    // Shadow and pipeline registers; reset flushes every in-flight pixel
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx_q    <= '0;
            sy_q    <= '0;
            flip_q  <= 1'b0;
            addr_q  <= '0;
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
            valid_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            flip_q  <= flip_d;
            addr_q  <= addr_d;
            hit1_q  <= hit1_d;
            hit2_q  <= hit2_d;
            valid_q <= valid_d;
            rgb_q   <= rgb_d;
        end
    end

    sprite_anim_ctr #(
        .NUM_FRAMES (NUM_FRAMES),
        .ANIM_DIV   (ANIM_DIV)
    ) u_anim (
        .clk          (Clk),
        .rst_n        (Reset_n),
        .i_frame_tick (frame_tick),
        .i_anim_en    (anim_en),
        .o_frame_sel  (frame_sel)
    );

    assign read_address = addr_q;
    assign pixel_rgb    = rgb_q;
    assign pixel_valid  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_fetch
//  Purpose  : Self-checking bench for sprite_fetch with a 1-cycle ROM model
//             (data = address, optional colour-key word injected).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_fetch;

    localparam int   SPR_W      = 32;
    localparam int   SPR_H      = 32;
    localparam int   NUM_FRAMES = 3;
    localparam int   ANIM_DIV   = 4;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
    logic        frame_tick, flip, anim_en;
    logic [18:0] read_address;
    logic [23:0] rom_data;
    logic [1:0]  frame_sel;
    logic [23:0] pixel_rgb;
    logic        pixel_valid;

    sprite_fetch #(
        .SPR_W       (SPR_W),
        .SPR_H       (SPR_H),
        .NUM_FRAMES  (NUM_FRAMES),
        .ANIM_DIV    (ANIM_DIV),
        .TRANSPARENT (KEY)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .frame_tick   (frame_tick),
        .SpriteX      (SpriteX),
        .SpriteY      (SpriteY),
        .flip         (flip),
        .anim_en      (anim_en),
        .read_address (read_address),
        .rom_data     (rom_data),
        .frame_sel    (frame_sel),
        .pixel_rgb    (pixel_rgb),
        .pixel_valid  (pixel_valid)
    );

    always #5 Clk = ~Clk;

    // Behavioural ROM: one clock of latency, key word at key_addr
    int key_addr = -1;

    function automatic logic [23:0] rom_word(input logic [18:0] a);
        if (int'(a) == key_addr) return KEY;
        return {5'd0, a};
    endfunction

    always @(posedge Clk) rom_data <= rom_word(read_address);

    // Checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard
    typedef struct {
        int          cyc;
        logic [18:0] addr;
        logic        valid;
        logic [23:0] rgb;
    } exp_t;

    exp_t addr_q[$];
    exp_t pix_q[$];
    int   cyc = 0;
    bit   in_reset = 1'b1;

    // Reference model state
    int m_sx, m_sy, m_div, m_fs;
    bit m_flip;

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_flip = 1'b0; m_div = 0; m_fs = 0;
    endtask

    // Drive one pixel (optionally with frame_tick) and push its expectation
    task automatic step(input int x, input int y, input bit tick);
        exp_t        e;
        int          rx, ry, a;
        bit          hit;
        logic [23:0] d;
        DrawX      = 10'(x);
        DrawY      = 10'(y);
        frame_tick = tick;
        rx  = x - m_sx;
        ry  = y - m_sy;
        hit = (rx >= 0) && (rx < SPR_W) && (ry >= 0) && (ry < SPR_H);
        a   = hit ? (ry * SPR_W + (m_flip ? (SPR_W - 1 - rx) : rx)) : 0;
        d   = rom_word(19'(a));
        e.cyc   = cyc;
        e.addr  = 19'(a);
        e.valid = hit && (d != KEY);
        e.rgb   = e.valid ? d : 24'd0;
        addr_q.push_back(e);
        pix_q.push_back(e);
        if (tick) begin
            m_sx   = int'(SpriteX);
            m_sy   = int'(SpriteY);
            m_flip = flip;
        end
        if (!anim_en) begin
            m_div = 0;
            m_fs  = 0;
        end else if (tick) begin
            if (m_div == ANIM_DIV - 1) begin
                m_div = 0;
                m_fs  = (m_fs == NUM_FRAMES - 1) ? 0 : m_fs + 1;
            end else begin
                m_div++;
            end
        end
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge Clk);
        check_val("drain", addr_q.size() + pix_q.size(), 0);
    endtask

    // Monitor: sample 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            cyc++;
            if (in_reset) begin
                check_val("rst_addr",  read_address, 0);
                check_val("rst_valid", pixel_valid, 0);
                check_val("rst_rgb",   pixel_rgb, 0);
                check_val("rst_fsel",  frame_sel, 0);
            end else begin
                check_val("frame_sel", frame_sel, m_fs);
                if (addr_q.size() > 0 && addr_q[0].cyc == cyc - 1) begin
                    check_val("read_address", read_address, addr_q[0].addr);
                    void'(addr_q.pop_front());
                end
                if (pix_q.size() > 0 && pix_q[0].cyc == cyc - 3) begin
                    check_val("pixel_valid", pixel_valid, pix_q[0].valid);
                    check_val("pixel_rgb",   pixel_rgb,   pix_q[0].rgb);
                    void'(pix_q.pop_front());
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        Reset_n    = 1'b0;
        DrawX      = 10'd105;
        DrawY      = 10'd52;
        SpriteX    = 10'd100;
        SpriteY    = 10'd50;
        flip       = 1'b0;
        anim_en    = 1'b0;
        frame_tick = 1'b0;
        in_reset   = 1'b1;
        model_reset();
        repeat (4) @(negedge Clk);
        Reset_n  = 1'b1;
        in_reset = 1'b0;

        // Latch (100,50), no mirror, then basic hit
        step(0, 0, 1'b1);
        step(105, 52, 1'b0);
        check_val("hit_addr", read_address, 69);
        step(0, 0, 1'b0);
        step(0, 0, 1'b0);
        check_val("hit_rgb",   pixel_rgb, 69);
        check_val("hit_valid", pixel_valid, 1);

        // Horizontal and vertical box edges
        step(99, 52, 1'b0);
        step(100, 52, 1'b0);
        step(131, 52, 1'b0);
        step(132, 52, 1'b0);
        step(105, 49, 1'b0);
        step(105, 81, 1'b0);
        step(105, 82, 1'b0);

        // Tick with a hit on the same clock: old flip still applies to it
        flip = 1'b1;
        step(105, 52, 1'b1);
        step(105, 52, 1'b0);
        check_val("flip_addr", read_address, 90);
        step(100, 52, 1'b0);
        step(131, 81, 1'b0);

        // Sprite near the right edge: no wrap to small DrawX
        SpriteX = 10'd600;
        flip    = 1'b0;
        step(0, 0, 1'b1);
        step(10, 52, 1'b0);
        step(605, 52, 1'b0);
        step(0, 0, 1'b0);
        step(0, 0, 1'b0);
        check_val("nowrap_valid", pixel_valid, 1);

        // Moving the sprite mid-frame has no effect until the next tick
        SpriteX = 10'd200;
        step(605, 52, 1'b0);
        step(205, 52, 1'b0);
        step(0, 0, 1'b1);
        step(205, 52, 1'b0);
        step(605, 52, 1'b0);
        drain();

        // Colour key at the hit address is see-through
        key_addr = 69;
        step(205, 52, 1'b0);
        step(206, 52, 1'b0);
        step(0, 0, 1'b0);
        check_val("key_valid", pixel_valid, 0);
        check_val("key_rgb",   pixel_rgb, 0);
        drain();
        key_addr = -1;

        // Random pixels around the sprite, occasional re-latch with random flip
        for (int i = 0; i < 60; i++) begin
            if (i % 15 == 7) flip = 1'($urandom_range(0, 1));
            step($urandom_range(190, 240), $urandom_range(40, 90), (i % 15 == 7));
        end

        // Animation: 12 ticks step 0,0,0,0,1,1,1,1,2,2,2,2 -> 0
        anim_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(210, 60, 1'b1);
            step(210, 60, 1'b0);
            check_val("anim_seq", frame_sel, ((k + 1) / 4) % 3);
        end
        for (int k = 0; k < 4; k++) step(0, 0, 1'b1);
        check_val("anim_one", frame_sel, 1);
        anim_en = 1'b0;
        step(0, 0, 1'b0);
        check_val("anim_clear", frame_sel, 0);

        // Reset in the middle of a stream of hits
        step(205, 52, 1'b0);
        step(206, 52, 1'b0);
        Reset_n  = 1'b0;
        in_reset = 1'b1;
        addr_q.delete();
        pix_q.delete();
        model_reset();
        repeat (2) @(negedge Clk);
        Reset_n  = 1'b1;
        in_reset = 1'b0;
        step(5, 5, 1'b0);
        step(40, 40, 1'b0);
        check_val("rst_mid_valid0", pixel_valid, 0);
        step(40, 40, 1'b0);
        check_val("rst_first_valid", pixel_valid, 1);
        check_val("rst_first_rgb",   pixel_rgb, 165);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
